// File: rtl/tolower_stream.sv
// tolower_stream
//   Streaming ASCII lowercase converter. Bytes arrive over a valid/ready
//   handshake. 'A'..'Z' (8'h41..8'h5A) are mapped to 'a'..'z'. Every other
//   byte passes through unchanged. Conversion happens at push time, so the
//   2-entry output FIFO holds bytes that are already converted.
//   in_ready and out_valid/out_data come only from registered state, which
//   cuts the combinational paths between the upstream and downstream
//   handshakes.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset; clears the FIFO and counters
//   in_valid   upstream byte present
//   in_ready   a byte can be accepted this cycle (FIFO not full)
//   in_data    upstream byte
//   out_valid  converted byte present (FIFO not empty)
//   out_ready  downstream takes the byte this cycle
//   out_data   converted byte at the head of the FIFO
//   clr_stats  synchronous clear of both counters; wins over a simultaneous push
//   char_count bytes accepted since reset/clear, saturating
//   conv_count accepted bytes that were uppercase letters, saturating
module tolower_stream #(
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [7:0]         in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [7:0]         out_data,
   input  logic               clr_stats,
   output logic [COUNT_W-1:0] char_count,
   output logic [COUNT_W-1:0] conv_count
);

   logic [1:0][7:0] entry;
   logic            rd_ptr;
   logic            wr_ptr;
   logic [1:0]      count;

   logic            is_upper;
   logic [7:0]      conv_data;
   logic            push;
   logic            pop;

   assign is_upper  = (in_data >= 8'h41) && (in_data <= 8'h5A);
   assign conv_data = is_upper ? (in_data + 8'h20) : in_data;

   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign out_data  = entry[rd_ptr];

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   // FIFO storage and pointers. Push and pop are independent: when both
   // happen, both pointers advance and the occupancy does not change.
   always_ff @(posedge clk) begin
      if (rst) begin
         entry  <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            entry[wr_ptr] <= conv_data;
            wr_ptr        <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Statistics. A clear takes priority over a push in the same cycle. That
   // byte still enters the FIFO, but it is not counted.
   always_ff @(posedge clk) begin
      if (rst || clr_stats) begin
         char_count <= '0;
         conv_count <= '0;
      end else if (push) begin
         if (char_count != {COUNT_W{1'b1}}) begin
            char_count <= char_count + COUNT_W'(1);
         end
         if (is_upper && (conv_count != {COUNT_W{1'b1}})) begin
            conv_count <= conv_count + COUNT_W'(1);
         end
      end
   end

endmodule

// File: doc/tolower_stream.md
# tolower_stream

Streaming ASCII lowercase converter: accepts one byte per cycle over a valid/ready handshake, maps uppercase letters 'A'–'Z' to 'a'–'z', and passes every other byte through unchanged. It is the inverse partner of the combinational uppercase converter (`num`). It sits on the character path where text normalised to uppercase must be restored, or normalised to lowercase. A 2-entry output buffer decouples upstream and downstream stalls. Saturating counters report total bytes and converted bytes.

## Interface
- COUNT_W, 16, width of both statistics counters
- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  synchronous, active-high reset, sampled on rising edge of clk
- in_valid  input  1  upstream byte present
- in_ready  output  1  block can accept a byte this cycle
- in_data  input  8  upstream byte
- out_valid  output  1  converted byte present
- out_ready  input  1  downstream accepts byte this cycle
- out_data  output  8  converted byte (head of buffer)
- clr_stats  input  1  synchronous clear of both counters
- char_count  output  COUNT_W  bytes accepted since reset/clear, saturating
- conv_count  output  COUNT_W  bytes that were changed by conversion, saturating

## Operation
- Conversion rule: if in_data is in 8'h41..8'h5A, the output is in_data + 8'h20. Otherwise output = in_data, including 8'h00..8'h40, 8'h5B..8'hFF, lowercase letters, and bytes ≥ 8'h80.
- Conversion is applied at push time. The buffer stores already-converted bytes.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- Buffer: 2-entry FIFO with read pointer, write pointer (1 bit each, wrap 1→0), and an occupancy count of 0..2.
- in_ready = (count != 2). It depends only on registered state; there is no combinational path from out_ready.
- out_valid = (count != 0). out_data = entry[rd_ptr]. There is no combinational path from in_* to out_*.
- Occupancy update:
  - Push without pop: count +1.
  - Pop without push: count −1.
  - Push and pop together: count unchanged, both pointers advance.
- When full, a push cannot happen, so a pop in that cycle only frees one slot. in_ready rises the following cycle.
- When empty, a push cannot pop the same byte in the same cycle. There is no bypass.
- Byte ordering is strictly preserved. No bytes are dropped or duplicated.
- Counters:
  - char_count increments on every push.
  - conv_count increments on every push whose byte is in 8'h41..8'h5A.
  - Both hold at all-ones; they do not wrap.
  - clr_stats forces both to 0 and takes priority over a simultaneous push. That push still enters the FIFO but is not counted.
- Upstream must hold in_data and in_valid stable until accepted. Downstream sees out_data stable while out_valid && !out_ready.

## Timing
- Reset values: count=0, rd_ptr=0, wr_ptr=0, out_valid=0, in_ready=1, out_data=8'h00 (buffer entries cleared), char_count=0, conv_count=0.
- Reset takes effect on the clk edge where rst=1 and overrides all other inputs. Any buffered bytes are discarded.
- Reset asserted mid-stream: the next cycle shows out_valid=0 and in_ready=1. Data pushed during the reset cycle is lost.
- Latency: a byte pushed at edge k is visible with out_valid=1 in the cycle after edge k. With out_ready held high, it pops at edge k+1.
- Throughput: 1 byte/cycle sustained with out_ready held high. Occupancy stays at 1 in steady state.
- After out_ready=0 for ≥2 accepted bytes, in_ready=0. The first pop re-opens in_ready one cycle later.
- Counters update on the same edge as the push and are visible the next cycle.

## Test plan
- Reset/idle: hold rst for 2 cycles with in_valid=1 → out_valid=0, in_ready=1, char_count=0, conv_count=0 after reset.
- Conversion sweep: push all 256 byte values 8'h00..8'hFF with out_ready=1 → 8'h41..8'h5A emerge as 8'h61..8'h7A, all others unchanged, in order. Final char_count=256, conv_count=26.
- Backpressure: out_ready=0, push 8'h48, 8'h49, and offer 8'h21:
  - 8'h48 and 8'h49 are accepted; in_ready goes low and 8'h21 is held upstream.
  - Raise out_ready: outputs are 8'h68, 8'h69, 8'h21 in order, each output once.
- Simultaneous push/pop with occupancy 1, running 20 cycles of random in_valid/out_ready → scoreboard matches with no loss or duplication. Occupancy never exceeds 2.
- Saturation/clear with COUNT_W=4: push 20 uppercase bytes → both counters hold at 4'hF. Assert clr_stats together with a push of 8'h5A → counters=0, and 8'h7A is still output.
- Mid-stream reset: with 2 bytes buffered, assert rst for 1 cycle → out_valid=0, buffered bytes never appear. A subsequent push of 8'h4B yields 8'h6B.
